uart_rx_byte: RTL and testbench

- Serial receiver for 8N1 UART. Downstream counterpart of the message transmitter: consumes the serial line and delivers one received byte per frame with a single-cycle valid strobe.
- Runs on the 48 MHz board clock with internal 16x oversampling.
- Supports a runtime 9600/38400 baud select, matching the transmit side's selection.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 48 ++++
 rtl/uart_rx_byte.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive path.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_TICK   = 4'd7;
  localparam logic [3:0]  LAST_TICK  = 4'd15;
  localparam int unsigned DATA_BITS  = 8;

  // Rounded divider from system clock to the oversampling tick rate.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator with two selectable rates. Held at zero while
// disabled so the tick phase starts fresh on every enable.
module uart_baud_tick #(
  parameter int unsigned CLK_FREQ   = 48000000,
  parameter int unsigned BAUD_LO    = 9600,
  parameter int unsigned BAUD_HI    = 38400,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sel,
  output logic tick
);
  import uart_pkg::*;

  localparam int unsigned DIV_LO  = calc_div(CLK_FREQ, BAUD_LO, OVERSAMPLE);
  localparam int unsigned DIV_HI  = calc_div(CLK_FREQ, BAUD_HI, OVERSAMPLE);
  localparam int unsigned DIV_MAX = (DIV_LO > DIV_HI) ? DIV_LO : DIV_HI;
  localparam int unsigned CW      = $clog2(DIV_MAX);

  localparam logic [CW-1:0] LAST_LO = CW'(DIV_LO - 1);
  localparam logic [CW-1:0] LAST_HI = CW'(DIV_HI - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;

  assign last = sel ? LAST_HI : LAST_LO;
  assign tick = enable && (cnt_q == last);

  // Next divider count: hold at zero when idle, wrap after the tick.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!enable || tick) begin
      cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling and runtime baud select.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ   = 48000000,
  parameter int unsigned BAUD_LO    = 9600,
  parameter int unsigned BAUD_HI    = 38400,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_sel,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
  import uart_pkg::*;

  logic        rx_meta, rxs, rxs_prev;
  uart_state_e state_q, state_d;
  logic [3:0]  t_q, t_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        sel_q, sel_d;
  logic        tick, tick_en, sample;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
  logic        par_bad;

  assign par_bad    = (^shift_q) ^ par_q;
  assign parity_err = perr_q;
`endif

  assign tick_en    = (state_q != StIdle);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_LO   (BAUD_LO),
    .BAUD_HI   (BAUD_HI),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(tick_en),
    .sel   (sel_q),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Last tick of the current bit period: mid-bit sample point for data/stop.
  assign sample = tick && (t_q == LAST_TICK);

  // Next-state and strobe logic for frame reception.
  always_comb begin
    state_d = state_q;
    t_d     = tick ? t_q + 4'd1 : t_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sel_d   = sel_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (rxs_prev && !rxs) begin
          sel_d   = baud_sel;
          t_d     = 4'd0;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick && (t_q == MID_TICK)) begin
          if (rxs) begin
            state_d = StIdle;  // glitch, not a real start bit
          end else begin
            t_d     = 4'd0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sample) begin
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample) begin
          par_d   = rxs;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (sample) begin
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad;
`endif
          if (rxs) begin
            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            valid_d = !par_bad;
`else
            valid_d = 1'b1;
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        // A held-low break must release before a new start can be seen.
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Receiver state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte. Runs the DUT from a 12 MHz clock so that
// DIV is 78 at 9600 baud and 20 at 38400 baud, keeping frames short.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int unsigned CLK_HZ = 12000000;
  localparam int BC_LO = 16 * 78;  // clocks per bit at 9600
  localparam int BC_HI = 16 * 20;  // clocks per bit at 38400
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 168;
  localparam int FRAME_BITS  = 11;
`else
  localparam int FRAME_TICKS = 152;
  localparam int FRAME_BITS  = 10;
`endif
  // start edge -> valid seen: 2 sync + 1 detect + ticks to mid stop bit
  localparam int LAT_LO = 3 + FRAME_TICKS * 78;
  localparam int LAT_HI = 3 + FRAME_TICKS * 20;

  logic       clk;
  logic       rst_n;
  logic       baud_sel;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  uart_rx_byte #(
    .CLK_FREQ  (CLK_HZ),
    .BAUD_LO   (9600),
    .BAUD_HI   (38400),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_sel  (baud_sel),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #41.667 clk = ~clk;

  // Free-running cycle counter and strobe monitors (sampled on negedge).
  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         both_cnt = 0;
  int         run_v = 0, run_f = 0, run_p = 0;
  int         max_v = 0, max_f = 0, max_p = 0;
  logic [7:0] vdata [16];
  int         vcyc  [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt <= valid_cnt + 1;
      if (valid_cnt < 16) begin
        vdata[valid_cnt] <= data_out;
        vcyc[valid_cnt]  <= cyc;
      end
      run_v <= run_v + 1;
      if (run_v + 1 > max_v) max_v <= run_v + 1;
    end else begin
      run_v <= 0;
    end
    if (frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      run_f    <= run_f + 1;
      if (run_f + 1 > max_f) max_f <= run_f + 1;
    end else begin
      run_f <= 0;
    end
    if (data_valid && frame_err) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin
      perr_cnt <= perr_cnt + 1;
      run_p    <= run_p + 1;
      if (run_p + 1 > max_p) max_p <= run_p + 1;
    end else begin
      run_p <= 0;
    end
`endif
  end

  // Drive one bit level for n clocks; entered and left at posedge+1.
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_raw(input logic [7:0] d, input logic par, input logic stop,
                                input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    drive_bit(par, bc);
    drive_bit(stop, bc);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
    send_frame_raw(d, ^d, stop, bc);
  endtask
`else
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    drive_bit(stop, bc);
  endtask
`endif

  task automatic test_reset();
    rst_n    = 1'b0;
    rx       = 1'b1;
    baud_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_data_out: got %h expected 00", data_out);
    end
    n_vec++;
    if (data_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_data_valid: got %b expected 0", data_valid);
    end
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single_9600();
    int v0, f0, t0;
    baud_sel = 1'b0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    t0 = cyc;
    fork
      send_frame(8'h76, 1'b1, BC_LO);
      begin
        repeat (BC_LO * 3) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL single_busy_mid: got %b expected 1", busy);
        end
      end
    join
    n_vec++;
    if (valid_cnt !== v0 + 1) begin
      n_err++; $display("FAIL single_valid_count: got %0d expected %0d", valid_cnt - v0, 1);
    end else begin
      n_vec++;
      if (vdata[v0] !== 8'h76) begin
        n_err++; $display("FAIL single_data: got %h expected 76", vdata[v0]);
      end
      n_vec++;
      if ((vcyc[v0] - t0 < LAT_LO - 2) || (vcyc[v0] - t0 > LAT_LO + 2)) begin
        n_err++;
        $display("FAIL single_latency: got %0d clk expected %0d", vcyc[v0] - t0, LAT_LO);
      end
    end
    n_vec++;
    if (ferr_cnt !== f0) begin
      n_err++; $display("FAIL single_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL single_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0, t0;
    baud_sel = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    t0 = cyc;
    fork
      begin
        send_frame(8'h6E, 1'b1, BC_HI);
        send_frame(8'h6F, 1'b1, BC_HI);
      end
      begin
        // Flip baud_sel inside frame one only; the latched rate must hold.
        repeat (400) @(posedge clk);
        #1 baud_sel = 1'b0;
        repeat (1600) @(posedge clk);
        #1 baud_sel = 1'b1;
      end
    join
    n_vec++;
    if (valid_cnt !== v0 + 2) begin
      n_err++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0);
    end else begin
      n_vec++;
      if (vdata[v0] !== 8'h6E) begin
        n_err++; $display("FAIL b2b_data0: got %h expected 6e", vdata[v0]);
      end
      n_vec++;
      if (vdata[v0 + 1] !== 8'h6F) begin
        n_err++; $display("FAIL b2b_data1: got %h expected 6f", vdata[v0 + 1]);
      end
      n_vec++;
      if ((vcyc[v0] - t0 < LAT_HI - 2) || (vcyc[v0] - t0 > LAT_HI + 2)) begin
        n_err++;
        $display("FAIL b2b_latency0: got %0d clk expected %0d", vcyc[v0] - t0, LAT_HI);
      end
      n_vec++;
      if (vcyc[v0 + 1] - vcyc[v0] !== FRAME_BITS * BC_HI) begin
        n_err++; $display("FAIL b2b_spacing: got %0d clk expected %0d",
                          vcyc[v0 + 1] - vcyc[v0], FRAME_BITS * BC_HI);
      end
    end
    n_vec++;
    if (ferr_cnt !== f0) begin
      n_err++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    baud_sel = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (60) @(posedge clk);  // 3 ticks low
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL glitch_busy_start: got %b expected 1", busy);
    end
    rx = 1'b1;
    repeat (110) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL glitch_busy_end: got %b expected 0", busy);
    end
    n_vec++;
    if ((valid_cnt !== v0) || (ferr_cnt !== f0)) begin
      n_err++; $display("FAIL glitch_strobes: got valid %0d ferr %0d expected 0 0",
                        valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    baud_sel = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, BC_HI);
    repeat (20 * BC_HI) @(posedge clk);  // break: rx stays low
    #1;
    n_vec++;
    if (ferr_cnt !== f0 + 1) begin
      n_err++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0);
    end
    n_vec++;
    if (valid_cnt !== v0) begin
      n_err++; $display("FAIL ferr_valid: got %0d pulses expected 0", valid_cnt - v0);
    end
    n_vec++;
    if (data_out !== 8'h6F) begin
      n_err++; $display("FAIL ferr_data_kept: got %h expected 6f", data_out);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL ferr_busy_break: got %b expected 1", busy);
    end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL ferr_busy_release: got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_midframe();
    int         v0, f0;
    logic [7:0] d;
    d        = 8'h3C;
    baud_sel = 1'b1;
    drive_bit(1'b0, BC_HI);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BC_HI);
    rx = d[4];
    repeat (BC_HI / 2) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_busy_before: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (data_out !== 8'h00) begin
      n_err++; $display("FAIL rstmid_data_out: got %h expected 00", data_out);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy);
    end
    n_vec++;
    if ((data_valid !== 1'b0) || (frame_err !== 1'b0)) begin
      n_err++; $display("FAIL rstmid_strobes: got valid %b ferr %b expected 0 0",
                        data_valid, frame_err);
    end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1, BC_HI);
    n_vec++;
    if (valid_cnt !== v0 + 1) begin
      n_err++; $display("FAIL rstmid_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    n_vec++;
    if (data_out !== 8'h3C) begin
      n_err++; $display("FAIL rstmid_data_after: got %h expected 3c", data_out);
    end
    n_vec++;
    if (ferr_cnt !== f0) begin
      n_err++; $display("FAIL rstmid_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0;
    baud_sel = 1'b1;
    v0 = valid_cnt;
    p0 = perr_cnt;
    send_frame_raw(8'h07, 1'b0, 1'b1, BC_HI);  // 3 ones, even parity needs 1
    n_vec++;
    if (perr_cnt !== p0 + 1) begin
      n_err++; $display("FAIL parity_bad_perr: got %0d expected 1", perr_cnt - p0);
    end
    n_vec++;
    if (valid_cnt !== v0) begin
      n_err++; $display("FAIL parity_bad_valid: got %0d expected 0", valid_cnt - v0);
    end
    n_vec++;
    if (data_out !== 8'h07) begin
      n_err++; $display("FAIL parity_bad_data: got %h expected 07", data_out);
    end
    send_frame_raw(8'h07, 1'b1, 1'b1, BC_HI);
    n_vec++;
    if ((valid_cnt !== v0 + 1) || (perr_cnt !== p0 + 1)) begin
      n_err++; $display("FAIL parity_good: got valid %0d perr %0d expected 1 0",
                        valid_cnt - v0, perr_cnt - p0 - 1);
    end
    n_vec++;
    if (data_out !== 8'h07) begin
      n_err++; $display("FAIL parity_good_data: got %h expected 07", data_out);
    end
  endtask
`endif

  task automatic test_strobes();
    n_vec++;
    if (max_v !== 1) begin
      n_err++; $display("FAIL valid_width: got %0d clk expected 1", max_v);
    end
    n_vec++;
    if (max_f !== 1) begin
      n_err++; $display("FAIL ferr_width: got %0d clk expected 1", max_f);
    end
    n_vec++;
    if (both_cnt !== 0) begin
      n_err++; $display("FAIL valid_ferr_overlap: got %0d expected 0", both_cnt);
    end
`ifdef UART_RX_PARITY_EN
    n_vec++;
    if (max_p !== 1) begin
      n_err++; $display("FAIL perr_width: got %0d clk expected 1", max_p);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_9600();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
